// File: rtl/fhn_stim_sequencer.sv
// Run controller for the FHN neuron core: core reset, settle/stimulus/relaxation
// protocol with latched config, per-sample strobe and hysteretic spike counting.
module fhn_stim_sequencer #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned SPK_W      = 8,
    parameter int unsigned RST_CYCLES = 10,
    parameter int unsigned SETTLE_CYC = 10,
    parameter int unsigned HYST       = 410
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] cfg_amp,
    input  logic [CNT_W-1:0]  cfg_stim_len,
    input  logic [CNT_W-1:0]  cfg_relax_len,
    input  logic [DATA_W-1:0] cfg_thresh,
    input  logic [DATA_W-1:0] v_in,
    output logic              core_rst,
    output logic [DATA_W-1:0] i_stim,
    output logic [2:0]        state,
    output logic              busy,
    output logic              sample_valid,
    output logic              spike,
    output logic [SPK_W-1:0]  spike_count,
    output logic              done
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StCrst   = 3'd1,
        StSettle = 3'd2,
        StStim   = 3'd3,
        StRelax  = 3'd4,
        StDone   = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  amp_q, thresh_q;
    logic [CNT_W-1:0]   stim_len_q, relax_len_q;
    logic               armed_q;

    logic               run_busy, accept_start, detect_en;
    logic               v_ge_thresh, v_below_rearm;
    logic signed [DATA_W:0] v_ext, rearm_lvl;

    assign state        = state_q;
    assign run_busy     = state_q inside {StCrst, StSettle, StStim, StRelax};
    assign accept_start = start && !abort && (state_q == StIdle || state_q == StDone);
    assign detect_en    = (state_q inside {StStim, StRelax}) && !abort;

    // One extra bit so thresh - HYST cannot wrap for thresholds near the negative limit.
    assign v_ext         = {v_in[DATA_W-1], v_in};
    assign rearm_lvl     = {thresh_q[DATA_W-1], thresh_q} - (DATA_W+1)'(HYST);
    assign v_ge_thresh   = $signed(v_in) >= $signed(thresh_q);
    assign v_below_rearm = v_ext < rearm_lvl;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (accept_start) begin
                    state_d = StCrst;
                    cnt_d   = CNT_W'(RST_CYCLES - 1);
                end
            end
            StCrst: begin
                if (cnt_q == '0) begin
                    state_d = StSettle;
                    cnt_d   = CNT_W'(SETTLE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    if (stim_len_q != '0) begin
                        state_d = StStim;
                        cnt_d   = stim_len_q - CNT_W'(1);
                    end else if (relax_len_q != '0) begin
                        state_d = StRelax;
                        cnt_d   = relax_len_q - CNT_W'(1);
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StStim: begin
                if (cnt_q == '0) begin
                    if (relax_len_q != '0) begin
                        state_d = StRelax;
                        cnt_d   = relax_len_q - CNT_W'(1);
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StRelax: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (abort && run_busy) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            amp_q        <= '0;
            thresh_q     <= '0;
            stim_len_q   <= '0;
            relax_len_q  <= '0;
            armed_q      <= 1'b0;
            core_rst     <= 1'b1;
            i_stim       <= '0;
            busy         <= 1'b0;
            sample_valid <= 1'b0;
            spike        <= 1'b0;
            spike_count  <= '0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            core_rst     <= (state_d == StIdle) || (state_d == StCrst);
            i_stim       <= (state_d == StStim) ? amp_q : '0;
            busy         <= state_d inside {StCrst, StSettle, StStim, StRelax};
            sample_valid <= state_d inside {StStim, StRelax};
            done         <= (state_d == StDone);
            spike        <= 1'b0;

            if (accept_start) begin
                amp_q       <= cfg_amp;
                thresh_q    <= cfg_thresh;
                stim_len_q  <= cfg_stim_len;
                relax_len_q <= cfg_relax_len;
                spike_count <= '0;
            end

            if (state_d == StSettle) begin
                armed_q <= 1'b1;
            end else if (detect_en) begin
                if (armed_q && v_ge_thresh) begin
                    spike   <= 1'b1;
                    armed_q <= 1'b0;
                    if (spike_count != '1) begin
                        spike_count <= spike_count + SPK_W'(1);
                    end
                end else if (!armed_q && v_below_rearm) begin
                    armed_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fhn_stim_sequencer.sv
// Bench for fhn_stim_sequencer: phase-timeline reference model checked every cycle,
// a spike-detector vector table, hand-written corner sequences and random runs.
module tb_fhn_stim_sequencer;
    localparam int RSTC = 10;
    localparam int SETC = 10;
    localparam int HYST = 410;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [15:0] cfg_amp, cfg_stim_len, cfg_relax_len, cfg_thresh, v_in;
    logic        core_rst, busy, sample_valid, spike, done;
    logic [15:0] i_stim;
    logic [2:0]  state;
    logic [7:0]  spike_count;
    logic [31:0] dut_vec;

    always #5 clk = ~clk;

    fhn_stim_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .cfg_amp      (cfg_amp),
        .cfg_stim_len (cfg_stim_len),
        .cfg_relax_len(cfg_relax_len),
        .cfg_thresh   (cfg_thresh),
        .v_in         (v_in),
        .core_rst     (core_rst),
        .i_stim       (i_stim),
        .state        (state),
        .busy         (busy),
        .sample_valid (sample_valid),
        .spike        (spike),
        .spike_count  (spike_count),
        .done         (done)
    );

    assign dut_vec = {state, core_rst, i_stim, busy, sample_valid, spike, spike_count, done};

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a run is a timeline indexed by cycles since start acceptance.
    int          m_mode = 0;
    int          m_k = 0;
    int          m_sl = 0;
    int          m_rl = 0;
    int          m_thr = 0;
    logic [15:0] m_amp = '0;
    bit          m_armed = 0;
    bit          m_spike = 0;
    int          m_count = 0;

    typedef struct {
        logic [15:0] v;
        bit          exp_spike;
        int          exp_count;
    } vec_t;
    vec_t vecs[15];

    function automatic int cur_phase();
        int base = RSTC + SETC;
        if (m_mode == 0) return 0;
        if (m_k <= RSTC) return 1;
        if (m_k <= base) return 2;
        if (m_k <= base + m_sl) return 3;
        if (m_k <= base + m_sl + m_rl) return 4;
        return 5;
    endfunction

    function automatic void model_edge();
        int cur = cur_phase();
        int v = int'($signed(v_in));
        m_spike = 0;
        if (!rst) begin
            m_mode  = 0;
            m_count = 0;
            m_armed = 0;
        end else if (abort && cur >= 1 && cur <= 4) begin
            m_mode = 0;
        end else if (start && !abort && (cur == 0 || cur == 5)) begin
            m_mode  = 1;
            m_k     = 1;
            m_amp   = cfg_amp;
            m_sl    = int'(cfg_stim_len);
            m_rl    = int'(cfg_relax_len);
            m_thr   = int'($signed(cfg_thresh));
            m_count = 0;
        end else begin
            if (cur == 3 || cur == 4) begin
                if (m_armed && v >= m_thr) begin
                    m_spike = 1;
                    m_armed = 0;
                    if (m_count < 255) m_count++;
                end else if (!m_armed && v < m_thr - HYST) begin
                    m_armed = 1;
                end
            end
            if (m_mode == 1 && cur != 5) m_k++;
            if (cur_phase() == 2) m_armed = 1;
        end
    endfunction

    function automatic logic [31:0] exp_vec();
        int          p = cur_phase();
        logic [15:0] istim = (p == 3) ? m_amp : 16'd0;
        logic        crst = (p <= 1);
        logic        bsy = (p >= 1 && p <= 4);
        logic        sv = (p == 3 || p == 4);
        logic        dn = (p == 5);
        return {3'(p), crst, istim, bsy, sv, m_spike, 8'(m_count), dn};
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("cycle_outputs", longint'(dut_vec), longint'(exp_vec()));
    endtask

    task automatic start_run(input logic [15:0] amp, input int sl, input int rl,
                             input logic [15:0] thr);
        cfg_amp       = amp;
        cfg_stim_len  = 16'(sl);
        cfg_relax_len = 16'(rl);
        cfg_thresh    = thr;
        start         = 1'b1;
        step();
        start         = 1'b0;
        // Scramble live config to prove the run uses the latched copy.
        cfg_amp       = 16'($urandom);
        cfg_stim_len  = 16'($urandom);
        cfg_relax_len = 16'($urandom);
        cfg_thresh    = 16'($urandom);
    endtask

    initial begin
        int n_crst, n_settle0, n_amp, n_relax0, n_sv, first_done, n_stim_seen;

        vecs[0]  = '{16'd0,     0, 0};
        vecs[1]  = '{16'd5000,  1, 1};
        vecs[2]  = '{16'd5000,  0, 1};
        vecs[3]  = '{16'd0,     0, 1};
        vecs[4]  = '{16'd5000,  1, 2};
        vecs[5]  = '{16'd0,     0, 2};
        vecs[6]  = '{16'd5000,  1, 3};
        vecs[7]  = '{16'd3900,  0, 3};
        vecs[8]  = '{16'd5000,  0, 3};
        vecs[9]  = '{16'd3686,  0, 3};
        vecs[10] = '{16'd4096,  0, 3};
        vecs[11] = '{16'd3685,  0, 3};
        vecs[12] = '{16'd4096,  1, 4};
        vecs[13] = '{16'h8000,  0, 4};
        vecs[14] = '{16'd4095,  0, 4};

        rst = 1'b0; start = 1'b0; abort = 1'b0; v_in = '0;
        cfg_amp = '0; cfg_stim_len = '0; cfg_relax_len = '0; cfg_thresh = '0;

        // Reset
        repeat (3) step();
        check("reset_state", state, 0);
        check("reset_core_rst", core_rst, 1);
        check("reset_i_stim", i_stim, 0);
        check("reset_count", spike_count, 0);
        check("reset_sample_valid", sample_valid, 0);
        check("reset_done", done, 0);
        rst = 1'b1;
        step();

        // Nominal protocol timing
        start_run(16'd4096, 4000, 20000, 16'h7fff);
        n_crst = 0; n_settle0 = 0; n_amp = 0; n_relax0 = 0; n_sv = 0; first_done = -1;
        for (int i = 0; i < 24025; i++) begin
            if (core_rst) n_crst++;
            if (state == 3'd2 && !core_rst && i_stim == 16'd0) n_settle0++;
            if (i_stim == 16'd4096) n_amp++;
            if (state == 3'd4 && i_stim == 16'd0) n_relax0++;
            if (sample_valid) n_sv++;
            if (done && first_done < 0) first_done = i;
            step();
        end
        check("nominal_core_rst_cycles", n_crst, 10);
        check("nominal_settle_cycles", n_settle0, 10);
        check("nominal_stim_cycles", n_amp, 4000);
        check("nominal_relax_cycles", n_relax0, 20000);
        check("nominal_sample_valid_cycles", n_sv, 24000);
        check("nominal_done_index", first_done, 24020);

        // Spike detector table, thresh 4096 (re-arm below 3686)
        start_run(16'd0, 100, 5, 16'd4096);
        repeat (20) step();
        check("table_in_stim", state, 3);
        for (int i = 0; i < 15; i++) begin
            v_in = vecs[i].v;
            step();
            check($sformatf("table_spike[%0d]", i), spike, vecs[i].exp_spike);
            check($sformatf("table_count[%0d]", i), spike_count, vecs[i].exp_count);
        end
        v_in = '0;
        repeat (100) step();
        check("table_run_done", done, 1);

        // Zero stimulus length: SETTLE goes straight to RELAX
        start_run(16'd1000, 0, 5, 16'h7fff);
        n_stim_seen = 0;
        repeat (20) begin
            if (state == 3'd3) n_stim_seen++;
            step();
        end
        check("zero_stim_relax_entry", state, 4);
        check("zero_stim_sample_valid", sample_valid, 1);
        check("zero_stim_i_stim", i_stim, 0);
        repeat (5) step();
        check("zero_stim_done", state, 5);
        check("zero_stim_no_stim_state", n_stim_seen, 0);

        // Both lengths zero: DONE right after SETTLE
        start_run(16'd1000, 0, 0, 16'h7fff);
        n_sv = 0;
        for (int i = 0; i < 25; i++) begin
            if (sample_valid) n_sv++;
            if (i == 20) check("zero_both_done_k21", state, 5);
            step();
        end
        check("zero_both_sample_valid", n_sv, 0);

        // Abort at STIM cycle 100 together with start; start ignored while busy
        start_run(16'd1234, 500, 10, 16'd4096);
        repeat (4) step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_start_ignored", state, 1);
        repeat (15) step();
        v_in = 16'd5000; step();
        v_in = 16'd0;    step();
        v_in = 16'd5000; step();
        v_in = 16'd0;    step();
        repeat (95) step();
        check("abort_pre_stim", i_stim, 1234);
        abort = 1'b1; start = 1'b1;
        step();
        abort = 1'b0; start = 1'b0;
        check("abort_state", state, 0);
        check("abort_core_rst", core_rst, 1);
        check("abort_i_stim", i_stim, 0);
        check("abort_sample_valid", sample_valid, 0);
        check("abort_count_held", spike_count, 2);
        step();
        check("abort_start_dropped", state, 0);

        // Saturation after 300 spikes
        start_run(16'd0, 1000, 0, 16'd4096);
        repeat (20) step();
        for (int i = 0; i < 300; i++) begin
            v_in = 16'd5000; step();
            v_in = 16'd0;    step();
        end
        check("saturate_count", spike_count, 255);
        repeat (420) step();
        check("saturate_done", done, 1);
        check("saturate_count_done", spike_count, 255);

        // Most negative threshold: re-arm level must not wrap
        start_run(16'd0, 50, 0, 16'h8000);
        v_in = 16'h8000;
        repeat (80) step();
        check("min_thresh_single_spike", spike_count, 1);
        check("min_thresh_done", done, 1);

        // Random runs against the model
        for (int i = 0; i < 3000; i++) begin
            start         = ($urandom % 8) == 0;
            abort         = ($urandom % 60) == 0;
            rst           = ($urandom % 400) != 0;
            cfg_amp       = 16'($urandom);
            cfg_stim_len  = 16'($urandom % 16);
            cfg_relax_len = 16'($urandom % 16);
            cfg_thresh    = 16'($urandom_range(1000) - 500);
            v_in          = 16'($urandom_range(2000) - 1000);
            step();
        end
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        step();
        check("final_reset_state", state, 0);
        rst = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
